// File: rtl/risc_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// M-extension funct3 codes and the funct3 bit that separates divides from multiplies.
package risc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } md_state_e;

  // funct3 values of the RV32M instructions
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct3[2] set means DIV/DIVU/REM/REMU
  localparam int unsigned MD_DIV_BIT = 2;

endpackage

// File: rtl/risc_md_downcounter.sv
// Loadable down-counter with a zero flag, used to time the MDU busy phase.
module risc_md_downcounter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/risc_muldiv_sequencer.sv
// Execute-stage controller for the shared iterative MDU. Starts the MDU, sequences
// its iteration steps and holds F/D/E (with bubbles into M) until the result is ready.
module risc_muldiv_sequencer
  import risc_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MdValidE,
  input  logic [2:0] MdOpE,
  input  logic       DivZeroE,
  output logic       MdLoad,
  output logic       MdStep,
  output logic       MdDoneE,
  output logic       MdBusy,
  output logic       StallF_md,
  output logic       StallD_md,
  output logic       StallE_md,
  output logic       FlushM_md
);

  // Counter preload is N-1 so that exactly N BUSY cycles elapse before DONE.
  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic             is_div;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             md_load, md_step, md_done, md_stall;

  // Only the divide/multiply selector bit matters to the sequencer.
  logic unused_funct3;
  assign unused_funct3 = ^MdOpE[1:0];
  assign is_div        = MdOpE[MD_DIV_BIT];

  risc_md_downcounter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // Next-state and raw output decode.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    md_load  = 1'b0;
    md_step  = 1'b0;
    md_done  = 1'b0;
    md_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MdValidE) begin
          md_load  = 1'b1;
          md_stall = 1'b1;
          if (is_div && DivZeroE) begin
            // Divide by zero has a fixed architectural result: no iterations needed.
            state_d = StDone;
          end else begin
            state_d  = StBusy;
            cnt_load = 1'b1;
            cnt_val  = is_div ? DivLoad : MulLoad;
          end
        end
      end
      StBusy: begin
        // E is frozen here, so the E-stage inputs are deliberately ignored.
        md_step  = 1'b1;
        md_stall = 1'b1;
        if (cnt_zero) begin
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        // MdValidE here belongs to the completing op, so never restart from DONE.
        md_done = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register, returned to IDLE asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low while reset is held, even if MdValidE is high in IDLE.
  always_comb begin
    MdLoad    = md_load & ~rst;
    MdStep    = md_step & ~rst;
    MdDoneE   = md_done & ~rst;
    MdBusy    = (state_q != StIdle) & ~rst;
    StallF_md = md_stall & ~rst;
    StallD_md = md_stall & ~rst;
    StallE_md = md_stall & ~rst;
    FlushM_md = md_stall & ~rst;
  end

endmodule

// File: tb/tb_risc_muldiv_sequencer.sv
// Directed bench for risc_muldiv_sequencer with default latencies (MUL 2, DIV 32).
module tb_risc_muldiv_sequencer;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       MdValidE;
  logic [2:0] MdOpE;
  logic       DivZeroE;
  logic       MdLoad, MdStep, MdDoneE, MdBusy;
  logic       StallF_md, StallD_md, StallE_md, FlushM_md;
  logic [7:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  risc_muldiv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .MdValidE (MdValidE),
    .MdOpE    (MdOpE),
    .DivZeroE (DivZeroE),
    .MdLoad   (MdLoad),
    .MdStep   (MdStep),
    .MdDoneE  (MdDoneE),
    .MdBusy   (MdBusy),
    .StallF_md(StallF_md),
    .StallD_md(StallD_md),
    .StallE_md(StallE_md),
    .FlushM_md(FlushM_md)
  );

  always #5 clk = ~clk;

  assign obs = {MdLoad, MdStep, MdDoneE, MdBusy, StallF_md, StallD_md, StallE_md, FlushM_md};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {load, step, done, busy, stallF, stallD, stallE, flushM} in cycle k of an op
  // with N busy cycles: cycle 0 is the IDLE start, 1..N busy, N+1 done.
  function automatic logic [7:0] exp_vec(input int k, input int n);
    logic s;
    s = (k <= n);
    return {(k == 0), (k >= 1 && k <= n), (k == n + 1), (k >= 1), s, s, s, s};
  endfunction

  // Run one M-op; MdValidE stays high throughout (including DONE) while the op
  // and divide-zero inputs are scrambled after the start cycle. abort_at >= 0 stops early.
  task automatic run_op(input string tag, input logic [2:0] op, input logic dz, input int n,
                        input int abort_at);
    int steps;
    steps = 0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k == abort_at) return;
      @(posedge clk);
      #1;
      MdValidE = 1'b1;
      if (k == 0) begin
        MdOpE    = op;
        DivZeroE = dz;
      end else begin
        MdOpE    = 3'($urandom);
        DivZeroE = 1'($urandom);
      end
      #3;
      check($sformatf("%s c%0d", tag, k), {24'd0, obs}, {24'd0, exp_vec(k, n)});
      if (MdStep) steps++;
    end
    check({tag, " steps"}, steps, n);
  endtask

  task automatic idle(input string tag, input int m);
    for (int i = 0; i < m; i++) begin
      @(posedge clk);
      #1;
      MdValidE = 1'b0;
      MdOpE    = 3'($urandom);
      DivZeroE = 1'($urandom);
      #3;
      check($sformatf("%s i%0d", tag, i), {24'd0, obs}, 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    MdValidE = 1'b1;
    MdOpE    = F3_MUL;
    DivZeroE = 1'b0;
    #4;
    check("reset_valid_hi", {24'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_clocked", {24'd0, obs}, 32'd0);
    rst      = 1'b0;
    MdValidE = 1'b0;
    idle("post_reset", 3);

    run_op("mul", F3_MUL, 1'b0, 2, -1);
    idle("gap1", 2);
    run_op("mulhu_dz", F3_MULHU, 1'b1, 2, -1);
    idle("gap2", 1);
    run_op("divu", F3_DIVU, 1'b0, 32, -1);
    idle("gap3", 1);
    run_op("div0", F3_DIV, 1'b1, 0, -1);
    idle("gap4", 1);

    // Second op enters E the edge after the first op's DONE cycle.
    run_op("b2b_mul", F3_MUL, 1'b0, 2, -1);
    run_op("b2b_rem", F3_REM, 1'b0, 32, -1);
    run_op("b2b_remu0", F3_REMU, 1'b1, 0, -1);
    idle("gap5", 1);

    // Reset asserted in cycle 10 of a DIV.
    run_op("div_abort", F3_DIV, 1'b0, 32, 10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    check("rst_mid_op", {24'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    MdValidE = 1'b0;
    #3;
    check("rst_release", {24'd0, obs}, 32'd0);
    idle("after_rst", 2);
    run_op("mul_after_rst", F3_MULH, 1'b0, 2, -1);

    idle("quiet", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
